pattern_timing_ctrl: RTL and testbench



---
 rtl/pattern_timing_ctrl.sv | 155 +++++++++++++++
 tb/tb_pattern_timing_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pattern_timing_ctrl.sv
// pattern_timing_ctrl: video raster timing (VS/HS/DE) plus pattern-select
// sequencer for the RGB test-pattern generator.
// A start/stop state machine always finishes the current frame before going
// idle. The pattern index only moves on frame boundaries.
// Optional macro PATTERN_TIMING_FRAME_CNT_EN enables the completed-frame
// counter on FRAME_CNT_O; without it FRAME_CNT_O is constant zero.
//
// state  | meaning
// S_IDLE | raster parked at h=v=0, outputs low, waiting for EN_I
// S_RUN  | raster running, EN_I held high
// S_STOP | raster running until the end of the current frame, EN_I low
module pattern_timing_ctrl #(
  parameter int C_H_ACTIVE = 1920,
  parameter int C_H_FP     = 88,
  parameter int C_H_SYNC   = 44,
  parameter int C_H_BP     = 148,
  parameter int C_V_ACTIVE = 1080,
  parameter int C_V_FP     = 4,
  parameter int C_V_SYNC   = 5,
  parameter int C_V_BP     = 36,
  parameter int C_PAT_NUM  = 4
) (
  input  logic        CLK_I,
  input  logic        RSTN_I,
  input  logic        EN_I,
  input  logic [7:0]  FRAME_HOLD_I,
  output logic        VS_O,
  output logic        HS_O,
  output logic        DE_O,
  output logic [7:0]  PAT_SEL_O,
  output logic        BUSY_O,
  output logic [15:0] FRAME_CNT_O
);

  localparam int H_TOT = C_H_ACTIVE + C_H_FP + C_H_SYNC + C_H_BP;
  localparam int V_TOT = C_V_ACTIVE + C_V_FP + C_V_SYNC + C_V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_DE    = HW'(C_H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(C_H_ACTIVE + C_H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(C_H_ACTIVE + C_H_FP + C_H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_DE    = VW'(C_V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(C_V_ACTIVE + C_V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(C_V_ACTIVE + C_V_FP + C_V_SYNC - 1);
  localparam logic [7:0]    PAT_LAST = 8'(C_PAT_NUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  state_t        state;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [7:0]    hold_cnt;
  logic [7:0]    pat;

  logic       active;
  logic       start;
  logic       frame_end;
  logic       go_idle;
  logic       de_dec;
  logic       hs_dec;
  logic       vs_dec;
  logic [7:0] hold_eff;
  logic       hold_done;

  assign active    = (state != S_IDLE);
  assign start     = (state == S_IDLE) && EN_I;
  assign frame_end = (h == H_LAST) && (v == V_LAST);
  // A stop only takes effect at the frame end when EN_I is still low there.
  assign go_idle   = (state == S_STOP) && frame_end && !EN_I;
  assign de_dec    = (h < H_DE) && (v < V_DE);
  assign hs_dec    = (h >= HS_BEG) && (h <= HS_END);
  assign vs_dec    = (v >= VS_BEG) && (v <= VS_END);
  assign hold_eff  = (FRAME_HOLD_I == 8'd0) ? 8'd1 : FRAME_HOLD_I;
  // >= rather than == so a hold value lowered mid-sequence cannot overshoot.
  assign hold_done = ({1'b0, hold_cnt} + 9'd1) >= {1'b0, hold_eff};

  // State machine, raster counters, pattern schedule and registered outputs.
  always_ff @(posedge CLK_I) begin
    if (!RSTN_I) begin
      state     <= S_IDLE;
      h         <= '0;
      v         <= '0;
      hold_cnt  <= '0;
      pat       <= '0;
      VS_O      <= 1'b0;
      HS_O      <= 1'b0;
      DE_O      <= 1'b0;
      BUSY_O    <= 1'b0;
      PAT_SEL_O <= '0;
    end else begin
      VS_O      <= active && vs_dec;
      HS_O      <= active && hs_dec;
      DE_O      <= active && de_dec;
      BUSY_O    <= active;
      PAT_SEL_O <= pat;
      case (state)
        S_IDLE: begin
          h <= '0;
          v <= '0;
          if (start) begin
            state    <= S_RUN;
            hold_cnt <= '0;
            pat      <= '0;
          end
        end
        default: begin
          if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + VW'(1);
          end else begin
            h <= h + HW'(1);
          end
          // The pattern for the next frame is settled at the frame end so it
          // leaves the output register together with the first DE of line 0.
          if (frame_end && !go_idle) begin
            if (hold_done) begin
              hold_cnt <= '0;
              pat      <= (pat == PAT_LAST) ? 8'd0 : pat + 8'd1;
            end else begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end
          if (EN_I)
            state <= S_RUN;
          else if (go_idle)
            state <= S_IDLE;
          else
            state <= S_STOP;
        end
      endcase
    end
  end

`ifdef PATTERN_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;

  // Completed-frame counter, cleared when a new run starts from idle.
  always_ff @(posedge CLK_I) begin
    if (!RSTN_I)
      frame_cnt <= '0;
    else if (start)
      frame_cnt <= '0;
    else if (active && frame_end)
      frame_cnt <= frame_cnt + 16'd1;
  end

  assign FRAME_CNT_O = frame_cnt;
`else
  assign FRAME_CNT_O = '0;
`endif

endmodule

// File: tb/tb_pattern_timing_ctrl.sv
// Testbench for pattern_timing_ctrl using a small 14x7 raster (98 clocks per
// frame). The reference model tracks the raster as a linear position within
// the frame and derives h/v and the sync/DE windows arithmetically.
// FRAME_CNT_O expectations follow PATTERN_TIMING_FRAME_CNT_EN.
module tb_pattern_timing_ctrl;

  localparam int HA = 8, HF = 2, HSW = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
  localparam int P  = 4;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FR = HT * VT;

  typedef struct packed {
    logic        vs;
    logic        hs;
    logic        de;
    logic        busy;
    logic [7:0]  pat;
    logic [15:0] fc;
  } obs_t;

  logic        clk;
  logic        rstn_i;
  logic        en_i;
  logic [7:0]  hold_i;
  logic        vs_o, hs_o, de_o, busy_o;
  logic [7:0]  pat_o;
  logic [15:0] fc_o;

  obs_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // reference model state
  bit m_run, m_stop;
  int m_t, m_pat, m_on, m_fc;

  pattern_timing_ctrl #(
    .C_H_ACTIVE(HA), .C_H_FP(HF), .C_H_SYNC(HSW), .C_H_BP(HB),
    .C_V_ACTIVE(VA), .C_V_FP(VF), .C_V_SYNC(VSW), .C_V_BP(VB),
    .C_PAT_NUM(P)
  ) dut (
    .CLK_I(clk), .RSTN_I(rstn_i), .EN_I(en_i), .FRAME_HOLD_I(hold_i),
    .VS_O(vs_o), .HS_O(hs_o), .DE_O(de_o), .PAT_SEL_O(pat_o),
    .BUSY_O(busy_o), .FRAME_CNT_O(fc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic en, input logic rstn, input logic [7:0] hold);
    obs_t e;
    int   h, v, hold_eff;
    bit   last, go_idle;
    @(negedge clk);
    en_i   = en;
    rstn_i = rstn;
    hold_i = hold;
    e = '0;
    if (!rstn) begin
      m_run = 0; m_stop = 0; m_t = 0; m_pat = 0; m_on = 0; m_fc = 0;
    end else begin
      h = m_t % HT;
      v = m_t / HT;
      if (m_run) begin
        e.de   = (h < HA) && (v < VA);
        e.hs   = (h >= HA + HF) && (h < HA + HF + HSW);
        e.vs   = (v >= VA + VF) && (v < VA + VF + VSW);
        e.busy = 1'b1;
      end
      e.pat = 8'(m_pat);
      if (!m_run) begin
        if (en) begin
          m_run = 1; m_stop = 0; m_t = 0; m_pat = 0; m_on = 0; m_fc = 0;
        end
      end else begin
        last    = (m_t == FR - 1);
        go_idle = !en && m_stop && last;
        if (last) m_fc = (m_fc + 1) % 65536;
        if (last && !go_idle) begin
          hold_eff = (hold == 8'd0) ? 1 : int'(hold);
          m_on++;
          if (m_on >= hold_eff) begin
            m_on  = 0;
            m_pat = (m_pat + 1) % P;
          end
        end
        m_t = (m_t + 1) % FR;
        if (en) m_stop = 0;
        else if (go_idle) m_run = 0;
        else m_stop = 1;
      end
    end
`ifdef PATTERN_TIMING_FRAME_CNT_EN
    e.fc = 16'(m_fc);
`else
    e.fc = '0;
`endif
    q.push_back(e);
  endtask

  // Monitor: after every edge with a pending expectation, compare all outputs.
  obs_t got, exp_o;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        cyc++;
        exp_o = q.pop_front();
        got.vs = vs_o; got.hs = hs_o; got.de = de_o; got.busy = busy_o;
        got.pat = pat_o; got.fc = fc_o;
        tests++;
        if (got !== exp_o) begin
          fails++;
          $display("FAIL outputs cycle %0d: got vs=%b hs=%b de=%b busy=%b pat=%0d fcnt=%0d, expected vs=%b hs=%b de=%b busy=%b pat=%0d fcnt=%0d",
                   cyc, got.vs, got.hs, got.de, got.busy, got.pat, got.fc,
                   exp_o.vs, exp_o.hs, exp_o.de, exp_o.busy, exp_o.pat, exp_o.fc);
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized run/stop episodes.
  initial begin
    int len;
    logic [7:0] hold;
    en_i = 1'b0; rstn_i = 1'b0; hold_i = 8'd2;
    m_run = 0; m_stop = 0; m_t = 0; m_pat = 0; m_on = 0; m_fc = 0;

    repeat (5) step(1'b1, 1'b0, 8'd2);
    repeat (9 * FR + 4) step(1'b1, 1'b1, 8'd2);
    repeat (3 * FR) step(1'b1, 1'b1, 8'd0);
    repeat (70) step(1'b0, 1'b1, 8'd0);
    repeat (150) step(1'b0, 1'b1, 8'd0);

    repeat (30) step(1'b1, 1'b1, 8'd1);
    repeat (30) step(1'b0, 1'b1, 8'd1);
    repeat (150) step(1'b1, 1'b1, 8'd1);

    repeat (50) step(1'b1, 1'b1, 8'd1);
    step(1'b1, 1'b0, 8'd1);
    repeat (200) step(1'b1, 1'b1, 8'd1);

    for (int k = 0; k < 20; k++) begin
      hold = 8'($urandom_range(0, 3));
      len = $urandom_range(20, 300);
      repeat (len) step(1'b1, 1'b1, hold);
      len = $urandom_range(1, 140);
      repeat (len) step(1'b0, 1'b1, hold);
      if ($urandom_range(0, 5) == 0)
        step(1'($urandom_range(0, 1)), 1'b0, hold);
      if ($urandom_range(0, 2) == 0)
        for (int i = 0; i < 200; i++)
          step(1'($urandom_range(0, 3) != 0), 1'b1, hold);
    end
    repeat (200) step(1'b0, 1'b1, 8'd1);

    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
